// File: rtl/sd_block_server_if.sv
// Block-server bus: initiator buffer side (sd_*) and backing-store byte port (mem_*).
// master = initiator/store environment, slave = the block server.
interface sd_block_server_if #(
    parameter int ADDR_W = 25
);
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_din;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              mem_ready;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_dout, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  mem_addr, mem_rd, mem_wr, mem_din
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_dout, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output mem_addr, mem_rd, mem_wr, mem_din
    );
endinterface

// File: rtl/sd_block_server.sv
// Serves 512-byte blocks between an SD-style initiator buffer and a byte store.
// Optional write protect: define SD_BLOCK_WP_EN to add the img_readonly input.
module sd_block_server #(
    parameter int ADDR_W = 25
) (
    input  logic clk,
    input  logic reset,
`ifdef SD_BLOCK_WP_EN
    input  logic img_readonly,
`endif
    sd_block_server_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_PUT,
        WR_ADDR, WR_CAP, WR_WAIT, DONE
    } state_t;

    state_t             state;
    logic [ADDR_W-10:0] lba;
    logic [8:0]         offset;
    logic               was_wr;
    logic               last;
    logic               wp;

    assign last = (offset == 9'd511);
    assign bus.mem_addr = {lba, offset};

`ifdef SD_BLOCK_WP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wp <= 1'b0;
        else if (state == IDLE && !bus.sd_rd && bus.sd_wr)
            wp <= img_readonly;
    end
`else
    assign wp = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            lba              <= '0;
            offset           <= '0;
            was_wr           <= 1'b0;
            bus.sd_ack       <= 1'b0;
            bus.sd_buff_addr <= '0;
            bus.sd_buff_dout <= '0;
            bus.sd_buff_wr   <= 1'b0;
            bus.mem_rd       <= 1'b0;
            bus.mem_wr       <= 1'b0;
            bus.mem_din      <= '0;
        end else begin
            bus.sd_buff_wr <= 1'b0;
            bus.mem_rd     <= 1'b0;
            bus.mem_wr     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.sd_rd || bus.sd_wr) begin
                        lba              <= bus.sd_lba[ADDR_W-10:0];
                        offset           <= '0;
                        bus.sd_buff_addr <= '0;
                        bus.sd_ack       <= 1'b1;
                        was_wr           <= !bus.sd_rd;
                        state            <= bus.sd_rd ? RD_REQ : WR_ADDR;
                    end
                end
                RD_REQ: begin
                    bus.mem_rd <= 1'b1;
                    state      <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (bus.mem_ready) begin
                        bus.sd_buff_dout <= bus.mem_dout;
                        state            <= RD_PUT;
                    end
                end
                RD_PUT: begin
                    bus.sd_buff_wr   <= 1'b1;
                    bus.sd_buff_addr <= offset;
                    offset           <= offset + 9'd1;
                    if (last) begin
                        bus.sd_ack <= 1'b0;
                        state      <= DONE;
                    end else begin
                        state <= RD_REQ;
                    end
                end
                WR_ADDR: begin
                    bus.sd_buff_addr <= offset;
                    state            <= WR_CAP;
                end
                WR_CAP: begin
                    bus.mem_din <= bus.sd_buff_din;
                    bus.mem_wr  <= !wp;
                    state       <= WR_WAIT;
                end
                WR_WAIT: begin
                    // Buffer address moves here so sd_buff_din has settled by WR_CAP.
                    if (bus.mem_ready || wp) begin
                        offset <= offset + 9'd1;
                        if (last) begin
                            bus.sd_ack <= 1'b0;
                            state      <= DONE;
                        end else begin
                            bus.sd_buff_addr <= offset + 9'd1;
                            state            <= WR_ADDR;
                        end
                    end
                end
                DONE: begin
                    // Wait for the served request level to drop; a still-pending
                    // request of the other kind is then accepted from IDLE.
                    if (was_wr ? !bus.sd_wr : !bus.sd_rd)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_block_server.sv
// Directed bench for sd_block_server: block read/write, arbitration, reset, re-arm.
// Store and initiator buffer are modelled; expected values are hand-computed.
module tb_sd_block_server;
    localparam int ADDR_W = 25;

    logic clk = 1'b0;
    logic reset;
`ifdef SD_BLOCK_WP_EN
    logic img_readonly;
`endif

    int checks = 0;
    int errors = 0;

    sd_block_server_if #(.ADDR_W(ADDR_W)) bus ();

    sd_block_server #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef SD_BLOCK_WP_EN
        .img_readonly (img_readonly),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Byte store: returns (addr & 0xFF), ready two cycles after the strobe.
    logic              pend = 1'b0;
    logic [ADDR_W-1:0] maddr;
    always @(posedge clk) begin
        bus.mem_ready <= 1'b0;
        if (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1) begin
            pend  <= 1'b1;
            maddr <= bus.mem_addr;
        end else if (pend) begin
            pend          <= 1'b0;
            bus.mem_ready <= 1'b1;
            bus.mem_dout  <= maddr[7:0];
        end
    end

    // Initiator buffer holds ~offset; data follows the address by one clock.
    always @(posedge clk) bus.sd_buff_din <= ~bus.sd_buff_addr[7:0];

    logic              mon_clr = 1'b0;
    int                rd_n, rd_bad, mr_n, mw_n, wr_bad, ack_max;
    logic [ADDR_W-1:0] mr_first, mr_last, mw_first, mw_last;
    logic [7:0]        exp_din;

    always @(negedge clk) begin
        if (mon_clr) begin
            rd_n = 0; rd_bad = 0; mr_n = 0; mw_n = 0; wr_bad = 0; ack_max = 0;
            mr_first = '0; mr_last = '0; mw_first = '0; mw_last = '0;
        end else begin
            if (bus.sd_buff_wr === 1'b1) begin
                if (bus.sd_buff_addr !== rd_n[8:0] || bus.sd_buff_dout !== rd_n[7:0])
                    rd_bad++;
                rd_n++;
            end
            if (bus.mem_rd === 1'b1) begin
                if (mr_n == 0) mr_first = bus.mem_addr;
                mr_last = bus.mem_addr;
                if (bus.mem_addr[8:0] !== mr_n[8:0]) rd_bad++;
                mr_n++;
            end
            if (bus.mem_wr === 1'b1) begin
                if (mw_n == 0) mw_first = bus.mem_addr;
                mw_last = bus.mem_addr;
                exp_din = ~mw_n[7:0];
                if (bus.mem_din !== exp_din || bus.mem_addr[8:0] !== mw_n[8:0])
                    wr_bad++;
                mw_n++;
            end
            if (bus.sd_ack === 1'b1 && int'(bus.sd_buff_addr) > ack_max)
                ack_max = int'(bus.sd_buff_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (bus.sd_ack !== lvl && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        assert (bus.sd_ack === lvl) else begin
            errors++;
            $error("FAIL %s: sd_ack %b expected %b (timeout)", tag, bus.sd_ack, lvl);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk); mon_clr = 1'b1;
        @(posedge clk); mon_clr = 1'b0;
        #1;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.sd_lba = '0;
        bus.sd_rd = 1'b0;
        bus.sd_wr = 1'b0;
`ifdef SD_BLOCK_WP_EN
        img_readonly = 1'b0;
`endif
        clear_mon();
        repeat (2) step();
        check("rst_ack", 32'(bus.sd_ack), 32'h0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
        check("rst_buff_wr", 32'(bus.sd_buff_wr), 32'h0);
        check("rst_buff_addr", 32'(bus.sd_buff_addr), 32'h0);
        check("rst_buff_dout", 32'(bus.sd_buff_dout), 32'h0);
        check("rst_mem_din", 32'(bus.mem_din), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        reset = 1'b0;
        step();

        // Block read of LBA 3.
        bus.sd_lba = 32'd3;
        bus.sd_rd = 1'b1;
        wait_ack(1'b1, "rd_ack_rise");
        bus.sd_rd = 1'b0;
        wait_ack(1'b0, "rd_ack_fall");
        settle();
        check("rd_pulses", rd_n, 32'd512);
        check("rd_seq", rd_bad, 32'd0);
        check("rd_strobes", mr_n, 32'd512);
        check("rd_first", 32'(mr_first), 32'h600);
        check("rd_last", 32'(mr_last), 32'h7FF);
        check("rd_no_wr", mw_n, 32'd0);

        // Block write of LBA 1.
        clear_mon();
        bus.sd_lba = 32'd1;
        bus.sd_wr = 1'b1;
        wait_ack(1'b1, "wr_ack_rise");
        bus.sd_wr = 1'b0;
        wait_ack(1'b0, "wr_ack_fall");
        settle();
        check("wr_pulses", mw_n, 32'd512);
        check("wr_data", wr_bad, 32'd0);
        check("wr_first", 32'(mw_first), 32'h200);
        check("wr_last", 32'(mw_last), 32'h3FF);
        check("wr_no_buff_wr", rd_n, 32'd0);

        // Read and write together: read first, held write follows.
        clear_mon();
        bus.sd_lba = 32'd2;
        bus.sd_rd = 1'b1;
        bus.sd_wr = 1'b1;
        wait_ack(1'b1, "both_ack_rise");
        bus.sd_rd = 1'b0;
        wait_ack(1'b0, "both_rd_done");
        settle();
        check("both_rd_pulses", rd_n, 32'd512);
        check("both_rd_first", 32'(mr_first), 32'h400);
        wait_ack(1'b1, "both_wr_start");
        bus.sd_wr = 1'b0;
        wait_ack(1'b0, "both_wr_done");
        settle();
        check("both_wr_pulses", mw_n, 32'd512);
        check("both_wr_first", 32'(mw_first), 32'h400);
        check("both_wr_data", wr_bad, 32'd0);

        // Reset in the middle of a read at offset 200.
        clear_mon();
        bus.sd_lba = 32'd3;
        bus.sd_rd = 1'b1;
        begin
            int n = 0;
            while (rd_n < 200 && n < 3000) begin step(); n++; end
        end
        check("mid_reached_200", rd_n, 32'd200);
        reset = 1'b1;
        #1;
        check("mid_rst_ack", 32'(bus.sd_ack), 32'h0);
        check("mid_rst_mem_rd", 32'(bus.mem_rd), 32'h0);
        check("mid_rst_buff_addr", 32'(bus.sd_buff_addr), 32'h0);
        check("mid_rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        clear_mon();
        reset = 1'b0;
        wait_ack(1'b1, "mid_restart");
        bus.sd_rd = 1'b0;
        wait_ack(1'b0, "mid_done");
        settle();
        check("mid_pulses", rd_n, 32'd512);
        check("mid_seq_from_0", rd_bad, 32'd0);
        check("mid_first", 32'(mr_first), 32'h600);

        // sd_rd held through DONE; upper LBA bits ignored.
        clear_mon();
        bus.sd_lba = 32'h8001_0000;
        bus.sd_rd = 1'b1;
        wait_ack(1'b1, "held_ack_rise");
        wait_ack(1'b0, "held_ack_fall");
        repeat (20) step();
        check("held_no_rearm", 32'(bus.sd_ack), 32'h0);
        check("held_pulses", rd_n, 32'd512);
        check("held_strobes", mr_n, 32'd512);
        check("held_first", 32'(mr_first), 32'h0);
        bus.sd_rd = 1'b0;
        step();
        bus.sd_rd = 1'b1;
        wait_ack(1'b1, "held_second");
        bus.sd_rd = 1'b0;
        wait_ack(1'b0, "held_second_done");
        settle();
        check("held_total", rd_n, 32'd1024);
        check("held_seq", rd_bad, 32'd0);
        check("held_last", 32'(mr_last), 32'h1FF);

`ifdef SD_BLOCK_WP_EN
        // Write-protected image: full sequence, no store writes.
        clear_mon();
        img_readonly = 1'b1;
        bus.sd_lba = 32'd1;
        bus.sd_wr = 1'b1;
        wait_ack(1'b1, "wp_ack_rise");
        bus.sd_wr = 1'b0;
        img_readonly = 1'b0;
        wait_ack(1'b0, "wp_ack_fall");
        settle();
        check("wp_no_mem_wr", mw_n, 32'd0);
        check("wp_addr_span", ack_max, 32'd511);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
